// File: rtl/glitch_trigger_gen.sv
// Armed one-shot trigger: waits for a selected edge on an asynchronous target
// line, counts a programmable delay, then drives a programmable-width pulse.
module glitch_trigger_gen #(
  parameter int DELAY_W     = 16,
  parameter int WIDTH_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               disarm,
  input  logic               edge_sel,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] pulse_width,
  input  logic               target_evt,
  output logic               trig,
  output logic               armed,
  output logic               busy,
  output logic [7:0]         fire_count,
  output logic [1:0]         state_dbg
);

  localparam int CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DELAY = 2'd2,
    S_PULSE = 2'd3
  } state_t;

  state_t               state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 hist_q;
  logic                 edge_q;
  logic [DELAY_W-1:0]   lat_delay_q;
  logic [WIDTH_W-1:0]   lat_width_q;
  logic                 lat_sel_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 trig_q;
  logic                 armed_q;
  logic                 busy_q;
  logic [7:0]           fire_q;

  logic                 sync_lvl;
  logic                 sel_edge;
  logic [CNT_W-1:0]     width_eff;
  logic [7:0]           fire_d;

  assign sync_lvl  = sync_q[SYNC_STAGES-1];
  assign sel_edge  = lat_sel_q ? (~sync_lvl & hist_q) : (sync_lvl & ~hist_q);
  assign width_eff = (lat_width_q == '0) ? CNT_W'(1) : CNT_W'(lat_width_q);
  assign fire_d    = (fire_q == 8'hFF) ? fire_q : fire_q + 8'd1;

  // History always follows the synchronized level, so at arm time it already
  // holds the current level and only later transitions register as edges.
  // The edge is registered once more, giving SYNC_STAGES + 1 cycles of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], target_evt};
      hist_q <= sync_lvl;
      edge_q <= (state_q == S_ARMED) && sel_edge;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_delay_q <= '0;
      lat_width_q <= '0;
      lat_sel_q   <= 1'b0;
      cnt_q       <= '0;
      trig_q      <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      fire_q      <= 8'd0;
    end else if (disarm) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_q     <= S_ARMED;
            lat_delay_q <= delay;
            lat_width_q <= pulse_width;
            lat_sel_q   <= edge_sel;
            armed_q     <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_ARMED: begin
          if (edge_q) begin
            armed_q <= 1'b0;
            if (lat_delay_q == '0) begin
              state_q <= S_PULSE;
              cnt_q   <= width_eff;
              trig_q  <= 1'b1;
              fire_q  <= fire_d;
            end else begin
              state_q <= S_DELAY;
              cnt_q   <= CNT_W'(lat_delay_q);
            end
          end
        end
        S_DELAY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_PULSE;
            cnt_q   <= width_eff;
            trig_q  <= 1'b1;
            fire_q  <= fire_d;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trig       = trig_q;
  assign armed      = armed_q;
  assign busy       = busy_q;
  assign fire_count = fire_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_glitch_trigger_gen.sv
// Bench for glitch_trigger_gen: drivers issue arm/edge scenarios and push the
// expected pulse (start edge, width, fire count); a monitor pops on each pulse.
module tb_glitch_trigger_gen;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst, arm, disarm, edge_sel, target_evt;
  logic [DW-1:0] delay;
  logic [WW-1:0] pulse_width;
  logic          trig, armed, busy;
  logic [7:0]    fire_count;
  logic [1:0]    state_dbg;

  glitch_trigger_gen #(.DELAY_W(DW), .WIDTH_W(WW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .arm(arm), .disarm(disarm), .edge_sel(edge_sel),
    .delay(delay), .pulse_width(pulse_width), .target_evt(target_evt),
    .trig(trig), .armed(armed), .busy(busy), .fire_count(fire_count),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / cycle index ----------------
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          model_fire = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: pulse begins at E + SS + 1 + delay, lasts max(width,1) unless cut.
  task automatic expect_pulse(input int unsigned start, input int unsigned width);
    model_fire = (model_fire < 255) ? model_fire + 1 : 255;
    exp_q.push_back({start[31:0], width[15:0], model_fire[7:0], 8'h00});
  endtask

  // ---------------- monitor ----------------
  bit          in_pulse = 1'b0;
  int unsigned p_start, p_len;
  logic [7:0]  p_fire;
  always @(negedge clk) begin
    if (trig === 1'b1) begin
      if (!in_pulse) begin
        in_pulse = 1'b1;
        p_start  = cyc;
        p_len    = 1;
        p_fire   = fire_count;
      end else begin
        p_len++;
      end
    end else if (in_pulse) begin
      logic [63:0] e;
      in_pulse = 1'b0;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got start=%0d width=%0d, expected no pulse", p_start, p_len);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_start", p_start, e[63:32]);
        chk("pulse_width", p_len, {16'd0, e[31:16]});
        chk("pulse_fire_count", {24'd0, p_fire}, {24'd0, e[15:8]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic settle(input logic lvl);
    target_evt = lvl;
    repeat (SS + 3) tick();
  endtask

  task automatic do_arm(input int unsigned d, input int unsigned w, input logic sel);
    delay = d[DW-1:0];
    pulse_width = w[WW-1:0];
    edge_sel = sel;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("armed_after_arm", {31'd0, armed}, 32'd1);
    chk("busy_after_arm", {31'd0, busy}, 32'd1);
    delay = DW'($urandom);
    pulse_width = WW'($urandom);
    edge_sel = ~sel;
  endtask

  task automatic run_fire(input int unsigned d, input int unsigned w, input logic sel,
                          input int unsigned gap, input bit inject, input bit extra);
    int unsigned e, start, weff;
    settle(sel);
    do_arm(d, w, sel);
    repeat (gap) tick();
    target_evt = ~sel;
    e = cyc + 1;
    start = e + SS + 1 + d;
    weff = (w == 0) ? 1 : w;
    expect_pulse(start, weff);
    wait_until(e + SS + 1);
    chk("armed_after_edge", {31'd0, armed}, 32'd0);
    chk("busy_after_edge", {31'd0, busy}, 32'd1);
    chk("trig_at_edge_plus3", {31'd0, trig}, (d == 0) ? 32'd1 : 32'd0);
    if (inject) begin
      arm = 1'b1;
      delay = DW'($urandom_range(0, 3));
      pulse_width = WW'($urandom_range(20, 40));
      tick();
      arm = 1'b0;
    end
    if (extra) begin
      target_evt = sel;
      tick();
      tick();
      target_evt = ~sel;
    end
    wait_until(start + weff + 1);
    chk("trig_after_pulse", {31'd0, trig}, 32'd0);
    chk("armed_after_pulse", {31'd0, armed}, 32'd0);
    chk("busy_after_pulse", {31'd0, busy}, 32'd0);
    chk("fire_count_after_pulse", {24'd0, fire_count}, model_fire);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_trig"}, {31'd0, trig}, 32'd0);
    chk({nm, "_armed"}, {31'd0, armed}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_fire"}, {24'd0, fire_count}, model_fire);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned e, start;
    rst = 1'b1; arm = 1'b0; disarm = 1'b0; edge_sel = 1'b0;
    delay = '0; pulse_width = '0; target_evt = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    chk("reset_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    tick();

    // basic rising edge, then falling with zero delay/width
    run_fire(5, 3, 1'b0, 10, 1'b0, 1'b0);
    run_fire(0, 0, 1'b1, 2, 1'b0, 1'b0);

    // level already high at arm: no fire until a fresh rising edge
    settle(1'b1);
    do_arm(1, 2, 1'b0);
    repeat (15) tick();
    chk("prearm_still_armed", {31'd0, armed}, 32'd1);
    target_evt = 1'b0;
    repeat (6) tick();
    chk("prearm_fall_ignored", {31'd0, armed}, 32'd1);
    target_evt = 1'b1;
    e = cyc + 1;
    start = e + SS + 2;
    expect_pulse(start, 2);
    wait_until(start + 3);
    target_evt = 1'b0;
    repeat (5) tick();
    target_evt = 1'b1;
    repeat (15) tick();
    chk("one_shot_fire_count", {24'd0, fire_count}, model_fire);
    chk("one_shot_busy", {31'd0, busy}, 32'd0);

    // disarm during DELAY: no pulse
    settle(1'b0);
    do_arm(10, 3, 1'b0);
    target_evt = 1'b1;
    e = cyc + 1;
    wait_until(e + 5);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    chk_all_zero("disarm_delay");
    wait_until(e + 20);

    // disarm in 2nd cycle of a 10-cycle pulse
    settle(1'b0);
    do_arm(2, 10, 1'b0);
    target_evt = 1'b1;
    e = cyc + 1;
    start = e + SS + 1 + 2;
    expect_pulse(start, 2);
    wait_until(start + 1);
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
    chk_all_zero("disarm_pulse");
    repeat (12) tick();

    // reset while ARMED, then arm is honoured again
    settle(1'b0);
    do_arm(4, 4, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_fire = 0;
    chk_all_zero("rst_armed");
    run_fire(3, 2, 1'b0, 1, 1'b0, 1'b0);

    // reset in 2nd cycle of a pulse
    settle(1'b0);
    do_arm(1, 10, 1'b0);
    target_evt = 1'b1;
    e = cyc + 1;
    start = e + SS + 1 + 1;
    expect_pulse(start, 2);
    wait_until(start + 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_fire = 0;
    chk_all_zero("rst_pulse");
    repeat (12) tick();

    // arm pulsed with new settings during DELAY is ignored
    run_fire(7, 4, 1'b0, 3, 1'b1, 1'b0);
    run_fire(9, 5, 1'b1, 0, 1'b1, 1'b1);

    // randomized scenarios
    for (int i = 0; i < 40; i++) begin
      run_fire($urandom_range(0, 20), $urandom_range(0, 12), 1'($urandom_range(0, 1)),
               $urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // saturation of fire_count
    for (int i = 0; i < 300; i++) begin
      run_fire(0, 1, 1'b0, 0, 1'b0, 1'b0);
    end
    chk("fire_count_saturated", {24'd0, fire_count}, 32'd255);

    repeat (20) tick();
    while (exp_q.size() != 0) begin
      logic [63:0] e_left;
      e_left = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_pulse: got none, expected start=%0d width=%0d", e_left[63:32], e_left[31:16]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion by cycle %0d, expected completion", cyc);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/glitch_trigger_gen.md
# glitch_trigger_gen

Arms on command, watches an asynchronous target event line, and after a programmable delay emits a single `trig` pulse of programmable width. It is the initiator on the trigger interface: its `trig` output drives the `trig` input of the clock-glitch modules. It replaces direct wiring of raw target GPIOs to the glitchers and gives cycle-exact, repeatable glitch placement relative to a target event.

## Interface
- `DELAY_W`, 16: width of the delay count in `clk` cycles.
- `WIDTH_W`, 8: width of the pulse-width count in `clk` cycles.
- `SYNC_STAGES`, 2: flip-flops in the `target_evt` synchronizer; minimum 2.

Clock and reset: one clock, `clk`; reset `rst` is synchronous and active-high.

- `clk` in 1: system clock, also the glitcher clock.
- `rst` in 1: synchronous, active-high reset.
- `arm` in 1: single-cycle request to arm.
- `disarm` in 1: abort; takes priority over `arm`.
- `edge_sel` in 1: 0 selects a rising edge of `target_evt`, 1 a falling edge; sampled on arm.
- `delay` in `DELAY_W`: cycles from edge detection to pulse start; sampled on arm.
- `pulse_width` in `WIDTH_W`: pulse length in cycles; 0 is treated as 1; sampled on arm.
- `target_evt` in 1: asynchronous event line from the target.
- `trig` out 1: registered trigger pulse to the glitcher.
- `armed` out 1: high while waiting for the target edge.
- `busy` out 1: high from arm acceptance until the pulse ends.
- `fire_count` out 8: number of pulses emitted, saturating at 255.

## Operation
- States: IDLE, ARMED, DELAY, PULSE.
- IDLE:
  - `arm`=1 and `disarm`=0 → ARMED.
  - `delay`, `pulse_width` and `edge_sel` are latched into internal registers.
  - The edge-detect history register is loaded with the current synchronized level, so an edge only counts if it occurs after arming.
- ARMED:
  - A selected edge on the synchronized `target_evt` → DELAY, with the counter loaded from the latched delay.
  - If the latched delay is 0, go → PULSE directly.
- DELAY: count down to 1, then → PULSE.
- PULSE:
  - `trig`=1 for exactly max(latched width, 1) cycles, then → IDLE.
  - `fire_count` increments once on entry to PULSE and holds at 255.
- Ignored inputs:
  - `arm` in any state other than IDLE has no effect.
  - Changes to `delay`, `pulse_width` or `edge_sel` after arming have no effect.
- `disarm` in any state → IDLE next cycle; `trig` is low from that cycle on; `fire_count` is unchanged. If a pulse is cut short by `disarm`, that pulse still counts.
- One-shot: after a pulse, the block returns to IDLE and needs a new `arm` to fire again.
- Edges arriving in DELAY or PULSE are ignored.

## Timing
- Reset values: `trig`=0, `armed`=0, `busy`=0, `fire_count`=0, state IDLE, synchronizer flops 0, latched delay and width 0.
- `rst` mid-operation aborts at the next edge with the values above; it has priority over all inputs.
- `armed` and `busy` go high on the cycle after the clock edge that samples `arm`.
- Edge-to-pulse latency: let edge E be the first `clk` edge at which `target_evt` is sampled at its new level.
  - `trig` is first high after edge E + `SYNC_STAGES` + 1 + `delay`.
  - Example: `SYNC_STAGES`=2, `delay`=0 → `trig` high 3 cycles after E.
- `armed` falls in the same cycle that DELAY or PULSE is entered.
- `busy` falls in the same cycle that `trig` falls.
- `trig` is a direct flop output with no combinational path from any input.
- An edge in the same cycle as `arm` is not detected, because the history register is loaded at arm.
- The delay counter never wraps: the maximum delay is 2^`DELAY_W`−1 cycles.

## Test plan
- Basic rising-edge fire:
  - Setup: arm with `delay`=5, `pulse_width`=3, `edge_sel`=0; raise `target_evt` 10 cycles later.
  - Expect: `trig` high for exactly 3 cycles starting 8 cycles after E; `fire_count`=1; `armed`=0 and `busy`=0 afterwards.
- Falling edge and zero values:
  - Setup: `target_evt` held high; arm with `delay`=0, `pulse_width`=0, `edge_sel`=1; drop `target_evt`.
  - Expect: a 1-cycle `trig` 3 cycles after E.
- Pre-armed level and re-arm:
  - Setup: `target_evt` already high when armed with `edge_sel`=0.
  - Expect: no fire. Then lower and raise `target_evt` → one pulse. A second rising edge without re-arm → no pulse; `fire_count` stays 1.
- Disarm:
  - Setup: `disarm` during DELAY, and separately during the 2nd cycle of a 10-cycle PULSE.
  - Expect: DELAY case → no pulse; PULSE case → `trig` low from the next cycle, `fire_count` incremented once; `busy`=0 after 1 cycle in both.
- Reset and saturation:
  - Setup: assert `rst` in ARMED and in PULSE; separately fire 300 times.
  - Expect: reset → all outputs 0 next cycle and `arm` still honoured afterwards; `fire_count` stops at 255.
- Ignored arm while busy:
  - Setup: change `delay` and pulse `arm` while in DELAY.
  - Expect: original latency and width preserved.
